shift_add_multiplier: RTL and testbench

//   Sequential N x N unsigned multiplier: consumes one multiplier bit per cycle,

---
 rtl/shift_add_multiplier.sv | 83 ++++++++
 tb/tb_shift_add_multiplier.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential N x N unsigned shift-and-add multiplier with start/ready/done handshake.
// Retires one multiplier bit per RUN cycle, so every operation takes N cycles.
module shift_add_multiplier #(
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           ready,
  output logic           done,
  output logic [2*N-1:0] p
);

  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] LastCount = CW'(N - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]     state_q;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic [2*N-1:0] acc_q;
  logic [CW-1:0]  count_q;

  logic [N-1:0]   pp;
  logic [2*N-1:0] pp_ext;
  logic [2*N-1:0] acc_d;

  // Partial product is the multiplicand gated by the current multiplier bit.
  always_comb begin
    pp     = a_q & {N{b_q[count_q]}};
    pp_ext = {{N{1'b0}}, pp} << count_q;
    acc_d  = acc_q + pp_ext;
  end

  always_comb begin
    ready = (state_q == StIdle);
    done  = (state_q == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      count_q <= '0;
      p       <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            acc_q   <= '0;
            count_q <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          acc_q <= acc_d;
          if (count_q == LastCount) begin
            p       <= acc_d;
            state_q <= StDone;
          end else begin
            count_q <= count_q + CW'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed and random checks of shift_add_multiplier at N=4 and N=8.
module tb_shift_add_multiplier;

  logic        clk;
  logic        rst;
  logic        s4, s8;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic        ready4, done4, ready8, done8;
  logic [7:0]  p4;
  logic [15:0] p8;

  int checks = 0;
  int errors = 0;

  shift_add_multiplier #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .start(s4), .a(a4), .b(b4),
    .ready(ready4), .done(done4), .p(p4)
  );

  shift_add_multiplier #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8),
    .ready(ready8), .done(done8), .p(p8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic op4(input logic [3:0] x, input logic [3:0] y, output int lat);
    int guard;
    guard = 0;
    while (!ready4 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    a4 = x; b4 = y; s4 = 1'b1;
    @(posedge clk); #1;
    s4 = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      check("rd_excl4", 64'(ready4 & done4), 64'd0);
    end while (!done4 && lat < 50);
  endtask

  task automatic op8(input logic [7:0] x, input logic [7:0] y, output int lat);
    int guard;
    guard = 0;
    while (!ready8 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    a8 = x; b8 = y; s8 = 1'b1;
    @(posedge clk); #1;
    s8 = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      check("rd_excl8", 64'(ready8 & done8), 64'd0);
    end while (!done8 && lat < 50);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [3:0] x4, y4;
    logic [7:0] x8, y8;

    rst = 1'b1; s4 = 1'b0; s8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;

    // 1: reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(ready4), 64'd1);
    check("rst_done", 64'(done4), 64'd0);
    check("rst_p", 64'(p4), 64'h00);
    check("rst_p8", 64'(p8), 64'h0000);
    rst = 1'b0;
    @(posedge clk); #1;

    // 2: 13 * 11
    op4(4'd13, 4'd11, lat);
    check("lat_13x11", 64'(lat), 64'd4);
    check("p_13x11", 64'(p4), 64'h8F);
    @(posedge clk); #1;
    check("done_1cyc", 64'(done4), 64'd0);
    check("ready_after", 64'(ready4), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("p_held", 64'(p4), 64'h8F);

    // 3: max and zero operands
    op4(4'hF, 4'hF, lat);
    check("p_15x15", 64'(p4), 64'hE1);
    @(posedge clk); #1;
    op4(4'h0, 4'h9, lat);
    check("lat_zero", 64'(lat), 64'd4);
    check("p_0x9", 64'(p4), 64'h00);
    @(posedge clk); #1;

    // 4: start during RUN/DONE is ignored
    a4 = 4'd3; b4 = 4'd5; s4 = 1'b1;
    @(posedge clk); #1;
    a4 = 4'd7; b4 = 4'd7;
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done4) begin
        pulses++;
        s4 = 1'b0;
      end
    end
    check("ign_pulses", 64'(pulses), 64'd1);
    check("ign_p", 64'(p4), 64'h0F);
    check("ign_ready", 64'(ready4), 64'd1);

    // 5: reset mid-operation
    a4 = 4'd9; b4 = 4'd6; s4 = 1'b1;
    @(posedge clk); #1;
    s4 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_ready", 64'(ready4), 64'd1);
    check("mid_rst_p", 64'(p4), 64'h00);
    pulses = 0;
    repeat (8) begin
      if (done4) pulses++;
      @(posedge clk); #1;
    end
    check("mid_rst_nodone", 64'(pulses), 64'd0);
    op4(4'd2, 4'd3, lat);
    check("p_2x3", 64'(p4), 64'h06);
    @(posedge clk); #1;

    // 6: random back-to-back
    for (int i = 0; i < 1000; i++) begin
      x4 = 4'($urandom_range(0, 15));
      y4 = 4'($urandom_range(0, 15));
      op4(x4, y4, lat);
      check("rand4", 64'(p4), 64'(8'(x4) * 8'(y4)));
      @(posedge clk); #1;
    end
    for (int i = 0; i < 1000; i++) begin
      x8 = 8'($urandom_range(0, 255));
      y8 = 8'($urandom_range(0, 255));
      op8(x8, y8, lat);
      check("rand8", 64'(p8), 64'(16'(x8) * 16'(y8)));
      @(posedge clk); #1;
    end
    op8(8'hFF, 8'hFF, lat);
    check("lat8", 64'(lat), 64'd8);
    check("p8_max", 64'(p8), 64'hFE01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
